// File: rtl/gb_ppu_pkg.sv
// rtl/gb_ppu_pkg.sv - shared PPU fetch-state type and VRAM region constants
package gb_ppu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP_A,
    ST_MAP_D,
    ST_LO_A,
    ST_LO_D,
    ST_HI_A,
    ST_HI_D,
    ST_PUSH
  } fetch_state_t;

  localparam logic [12:0] MAP0_BASE         = 13'h1800;
  localparam logic [12:0] MAP1_BASE         = 13'h1C00;
  localparam logic [12:0] TDATA_SIGNED_BASE = 13'h1000;

  function automatic logic is_access(input fetch_state_t s);
    return (s == ST_MAP_A) || (s == ST_LO_A) || (s == ST_HI_A);
  endfunction

endpackage

// File: rtl/gb_bg_fetcher_if.sv
// rtl/gb_bg_fetcher_if.sv - VRAM read port and BG pixel-row stream between fetcher and its peers
interface gb_bg_fetcher_if;
  logic [12:0] vadr;
  logic        vread;
  logic [7:0]  vdata;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_lo;
  logic [7:0]  pix_hi;

  modport master (
    output vadr, vread, pix_valid, pix_lo, pix_hi,
    input  vdata, pix_ready
  );

  modport slave (
    input  vadr, vread, pix_valid, pix_lo, pix_hi,
    output vdata, pix_ready
  );
endinterface

// File: rtl/gb_bg_fetch_adr.sv
// rtl/gb_bg_fetch_adr.sv - combinational tile-map / tile-data VRAM address generator
module gb_bg_fetch_adr
  import gb_ppu_pkg::*;
(
  input  logic [7:0]  ly,
  input  logic [4:0]  scx_tile,
  input  logic [7:0]  scy,
  input  logic        map_sel,
  input  logic        tdata_sel,
  input  logic [4:0]  tile_cnt,
  input  logic [7:0]  tnum,
  input  logic        is_map,
  input  logic        plane,
  output logic [12:0] addr
);

  logic [7:0] y;
  logic [4:0] col;

  always_comb begin
    y   = ly + scy;
    col = scx_tile + tile_cnt;
    if (is_map) begin
      addr = (map_sel ? MAP1_BASE : MAP0_BASE) | {3'b000, y[7:3], col};
    end else begin
      // signed mode: tiles 0x00..0x7F live above 0x1000, 0x80..0xFF share the 0x0800 block
      addr = ((~tdata_sel & ~tnum[7]) ? TDATA_SIGNED_BASE : 13'h0000) |
             {1'b0, tnum, y[2:0], plane};
    end
  end

endmodule

// File: rtl/gb_bg_fetcher.sv
// rtl/gb_bg_fetcher.sv - per-scanline background tile fetcher feeding the BG pixel FIFO
module gb_bg_fetcher
  import gb_ppu_pkg::*;
#(
  parameter int TILES_PER_LINE = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         ly,
  input  logic [7:0]         scx,
  input  logic [7:0]         scy,
  input  logic               bg_map_sel,
  input  logic               tile_data_sel,
  output logic               busy,
  output logic               done,
  gb_bg_fetcher_if.master    bus
);

  localparam logic [4:0] LAST_TILE = 5'(TILES_PER_LINE - 1);

  fetch_state_t state, state_n;

  logic [7:0]  l_ly, l_ly_n, l_scy, l_scy_n;
  logic [4:0]  l_scx, l_scx_n;
  logic        l_map, l_map_n, l_tds, l_tds_n;
  logic [4:0]  cnt, cnt_n;
  logic [7:0]  tnum, lo, tnum_adr;
  logic        done_n;
  logic [12:0] adr;
  logic        scx_fine_unused;

  assign scx_fine_unused = ^scx[2:0];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    l_ly_n  = l_ly;
    l_scy_n = l_scy;
    l_scx_n = l_scx;
    l_map_n = l_map;
    l_tds_n = l_tds;
    done_n  = 1'b0;
    case (state)
      ST_IDLE:  state_n = ST_IDLE;
      ST_MAP_A: state_n = ST_MAP_D;
      ST_MAP_D: state_n = ST_LO_A;
      ST_LO_A:  state_n = ST_LO_D;
      ST_LO_D:  state_n = ST_HI_A;
      ST_HI_A:  state_n = ST_HI_D;
      ST_HI_D:  state_n = ST_PUSH;
      ST_PUSH: begin
        if (bus.pix_ready) begin
          if (cnt == LAST_TILE) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_MAP_A;
            cnt_n   = cnt + 5'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // a new start always restarts the line, even over an accepting PUSH
    if (start) begin
      state_n = ST_MAP_A;
      cnt_n   = 5'd0;
      l_ly_n  = ly;
      l_scy_n = scy;
      l_scx_n = scx[7:3];
      l_map_n = bg_map_sel;
      l_tds_n = tile_data_sel;
      done_n  = 1'b0;
    end
    tnum_adr = (state == ST_MAP_D) ? bus.vdata : tnum;
  end

  // address is computed for the state being entered so vadr is registered with vread
  gb_bg_fetch_adr u_adr (
    .ly       (l_ly_n),
    .scx_tile (l_scx_n),
    .scy      (l_scy_n),
    .map_sel  (l_map_n),
    .tdata_sel(l_tds_n),
    .tile_cnt (cnt_n),
    .tnum     (tnum_adr),
    .is_map   (state_n == ST_MAP_A),
    .plane    (state_n == ST_HI_A),
    .addr     (adr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= 5'd0;
      l_ly          <= 8'd0;
      l_scy         <= 8'd0;
      l_scx         <= 5'd0;
      l_map         <= 1'b0;
      l_tds         <= 1'b0;
      tnum          <= 8'd0;
      lo            <= 8'd0;
      bus.vadr      <= 13'd0;
      bus.vread     <= 1'b0;
      bus.pix_valid <= 1'b0;
      bus.pix_lo    <= 8'd0;
      bus.pix_hi    <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      l_ly          <= l_ly_n;
      l_scy         <= l_scy_n;
      l_scx         <= l_scx_n;
      l_map         <= l_map_n;
      l_tds         <= l_tds_n;
      bus.vread     <= is_access(state_n);
      bus.pix_valid <= (state_n == ST_PUSH);
      busy          <= (state_n != ST_IDLE);
      done          <= done_n;
      if (is_access(state_n)) bus.vadr <= adr;
      if (state == ST_MAP_D) tnum <= bus.vdata;
      if (state == ST_LO_D) lo <= bus.vdata;
      if (state == ST_HI_D && state_n == ST_PUSH) begin
        bus.pix_lo <= lo;
        bus.pix_hi <= bus.vdata;
      end
    end
  end

endmodule
